pipe_stage_skid: RTL



---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_slot.sv | 31 +++
 rtl/pipe_stage_skid.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register.
package pipe_pkg;

  // Number of held entries; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload/control register; control is cleared whenever the slot empties.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              load,
  input  logic              kill_ctrl,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Kill wins over load so a flushed slot never exposes live control.
  always_ff @(posedge clk) begin
    if (CLR) begin
      data <= '0;
      ctrl <= '0;
    end else if (kill_ctrl) begin
      ctrl <= '0;
    end else if (load) begin
      data <= load_data;
      ctrl <= load_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage register with optional two-entry skid and bubble zeroing.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  state_t st, st_nxt;
  logic in_ready_q;
  logic in_fire, out_fire;
  logic main_load, main_from_skid, main_kill;
  logic skid_load, skid_kill;
  logic [DATA_W-1:0] main_load_data, skid_data;
  logic [CTRL_W-1:0] main_load_ctrl, skid_ctrl;

  assign out_valid = (st != ST_EMPTY);
  assign occupancy = 2'(st);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // State and registered ready; ready is low only when the next state is FULL.
  always_ff @(posedge clk) begin
    if (CLR) begin
      st         <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      st         <= st_nxt;
      in_ready_q <= (st_nxt != ST_FULL);
    end
  end

  always_comb begin
    st_nxt         = st;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_kill      = 1'b0;
    skid_load      = 1'b0;
    skid_kill      = 1'b0;
    if (flush) begin
      st_nxt    = ST_EMPTY;
      main_kill = 1'b1;
      skid_kill = 1'b1;
    end else begin
      case (st)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            st_nxt    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            if (SKID != 0) begin
              skid_load = 1'b1;
              st_nxt    = ST_FULL;
            end
          end else if (out_fire) begin
            main_kill = 1'b1;
            st_nxt    = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_kill      = 1'b1;
            st_nxt         = ST_ONE;
          end
        end
        default: st_nxt = ST_EMPTY;
      endcase
    end
  end

  assign main_load_data = main_from_skid ? skid_data : in_data;
  assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk       (clk),
    .CLR       (CLR),
    .load      (main_load),
    .kill_ctrl (main_kill),
    .load_data (main_load_data),
    .load_ctrl (main_load_ctrl),
    .data      (out_data),
    .ctrl      (out_ctrl)
  );

  // Skid mode registers ready; single-slot mode passes downstream ready through.
  if (SKID != 0) begin : g_skid
    assign in_ready = in_ready_q;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk       (clk),
      .CLR       (CLR),
      .load      (skid_load),
      .kill_ctrl (skid_kill),
      .load_data (in_data),
      .load_ctrl (in_ctrl),
      .data      (skid_data),
      .ctrl      (skid_ctrl)
    );
  end else begin : g_no_skid
    assign in_ready  = ~CLR & (~out_valid | out_ready);
    assign skid_data = '0;
    assign skid_ctrl = '0;
  end

endmodule
